tdm_demux4: RTL and testbench



---
 rtl/tdm_demux4.sv | 94 +++++++++
 tb/tb_tdm_demux4.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Four-channel TDM receive demultiplexer: aligns on a sync marker, collects one
// sample per slot into shadow registers and presents complete frames on a..d.
module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         sync,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic         frame_valid,
    output logic [1:0]   slot,
    output logic         locked,
    output logic         sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t       state_q;
    logic [1:0]   slot_q;
    logic [1:0]   slot_d;
    logic [W-1:0] shadow_q [4];
    logic [W-1:0] a_q, b_q, c_q, d_q;
    logic         frame_valid_q;
    logic         sync_err_q;

    always_comb begin
        slot_d = slot_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            for (int unsigned i = 0; i < 4; i++) shadow_q[i] <= '0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            d_q           <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    HUNT: begin
                        if (sync) begin
                            shadow_q[0] <= in_data;
                            slot_q      <= 2'd1;
                            state_q     <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (sync) begin
                            // Sync anywhere but slot 0 abandons the partial frame.
                            sync_err_q  <= (slot_q != 2'd0);
                            shadow_q[0] <= in_data;
                            slot_q      <= 2'd1;
                        end else begin
                            shadow_q[slot_q] <= in_data;
                            slot_q           <= slot_d;
                            if (slot_q == 2'd3) begin
                                a_q           <= shadow_q[0];
                                b_q           <= shadow_q[1];
                                c_q           <= shadow_q[2];
                                d_q           <= in_data;
                                frame_valid_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign c           = c_q;
    assign d           = d_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCK);
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios followed by random
// traffic, all compared against a queue-based frame model.
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] a, b, c, d;
    logic         frame_valid;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;

    int ncmp = 0;
    int nfail = 0;

    // Model: an unlocked receiver ignores everything until sync; a locked one
    // collects samples into frag and publishes them once four have arrived.
    bit           m_locked;
    logic [W-1:0] frag[$];
    logic [W-1:0] m_out [4];
    bit           m_fv;
    bit           m_err;

    tdm_demux4 #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .sync        (sync),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":a"}, 8'(a), 8'(m_out[0]));
        chk({where, ":b"}, 8'(b), 8'(m_out[1]));
        chk({where, ":c"}, 8'(c), 8'(m_out[2]));
        chk({where, ":d"}, 8'(d), 8'(m_out[3]));
        chk({where, ":frame_valid"}, 8'(frame_valid), 8'(m_fv));
        chk({where, ":sync_err"}, 8'(sync_err), 8'(m_err));
        chk({where, ":locked"}, 8'(locked), 8'(m_locked));
        chk({where, ":slot"}, 8'(slot), 8'(frag.size() % 4));
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        frag.delete();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_fv  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit s, input logic [W-1:0] x);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_locked = 1'b1;
                frag.delete();
                frag.push_back(x);
            end
        end else if (s) begin
            m_err = (frag.size() != 0);
            frag.delete();
            frag.push_back(x);
        end else begin
            frag.push_back(x);
            if (frag.size() == 4) begin
                for (int i = 0; i < 4; i++) m_out[i] = frag[i];
                m_fv = 1'b1;
                frag.delete();
            end
        end
    endtask

    task automatic step(input string where, input bit v, input bit s, input logic [W-1:0] x);
        @(negedge clk);
        in_valid = v;
        sync     = s;
        in_data  = x;
        @(posedge clk);
        #1;
        model_step(v, s, x);
        check_all(where);
    endtask

    task automatic idle(input string where, input int n);
        for (int i = 0; i < n; i++) step(where, 1'b0, 1'b1, 4'hF);
    endtask

    task automatic frame(input string where, input logic [W-1:0] x0, input logic [W-1:0] x1,
                         input logic [W-1:0] x2, input logic [W-1:0] x3, input int gap);
        step(where, 1'b1, 1'b1, x0);
        idle(where, gap);
        step(where, 1'b1, 1'b0, x1);
        idle(where, gap);
        step(where, 1'b1, 1'b0, x2);
        idle(where, gap);
        step(where, 1'b1, 1'b0, x3);
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock edge.
    task automatic async_reset(input string where);
        @(negedge clk);
        in_valid = 1'b0;
        sync     = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(where);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        #13 rst = 1'b0;

        frame("normal", 4'd1, 4'd2, 4'd3, 4'd4, 0);
        idle("normal_hold", 2);

        async_reset("rst2");
        step("hunt", 1'b1, 1'b0, 4'd7);
        step("hunt", 1'b1, 1'b0, 4'd8);
        frame("hunt_frame", 4'd1, 4'd2, 4'd3, 4'd4, 0);

        frame("gaps", 4'd5, 4'd6, 4'd7, 4'd8, 3);
        idle("gaps_hold", 3);

        step("missync", 1'b1, 1'b1, 4'd1);
        step("missync", 1'b1, 1'b0, 4'd2);
        frame("missync_frame", 4'd9, 4'd10, 4'd11, 4'd12, 0);

        for (int f = 0; f < 3; f++)
            frame("b2b", 4'(4*f), 4'(4*f+1), 4'(4*f+2), 4'(4*f+3), 0);

        step("sync_at_slot3", 1'b1, 1'b1, 4'd1);
        step("sync_at_slot3", 1'b1, 1'b0, 4'd2);
        step("sync_at_slot3", 1'b1, 1'b0, 4'd3);
        step("sync_at_slot3", 1'b1, 1'b1, 4'd13);
        step("sync_at_slot3", 1'b1, 1'b0, 4'd14);

        step("midrst", 1'b1, 1'b1, 4'd1);
        step("midrst", 1'b1, 1'b0, 4'd2);
        async_reset("midrst_now");
        step("midrst_after", 1'b1, 1'b0, 4'd3);
        frame("midrst_frame", 4'd5, 4'd6, 4'd7, 4'd8, 0);

        for (int i = 0; i < 400; i++) begin
            bit           v, s;
            logic [W-1:0] x;
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rand_rst");
            end else begin
                v = ($urandom_range(0, 3) != 0);
                if (!m_locked || frag.size() == 0)
                    s = ($urandom_range(0, 3) != 0);
                else
                    s = ($urandom_range(0, 15) == 0);
                x = W'($urandom_range(0, 15));
                step("random", v, s, x);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
